// File: rtl/pipeline_control.sv
// Pipeline sequencing and hazard control: run/step/drain FSM, load-use stall
// detection, branch flush, halt retirement and an enabled-cycle counter.
module pipeline_control #(
  parameter int unsigned NB_REG_ADDR  = 5,
  parameter int unsigned NB_CYCLE     = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_mode,
  input  logic                   i_step,
  input  logic                   i_halt_decoded,
  input  logic                   i_branch_taken,
  input  logic                   i_id_ex_mem_read,
  input  logic [NB_REG_ADDR-1:0] i_id_ex_rt,
  input  logic [NB_REG_ADDR-1:0] i_if_id_rs,
  input  logic [NB_REG_ADDR-1:0] i_if_id_rt,
  output logic                   o_pipe_enable,
  output logic                   o_pc_write,
  output logic                   o_if_id_write,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_bubble,
  output logic                   o_running,
  output logic                   o_done,
  output logic [NB_CYCLE-1:0]    o_cycle_count
);

  localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [NB_DRAIN-1:0]  drain_cnt_q, drain_cnt_d;
  logic [NB_CYCLE-1:0]  cycle_q, cycle_d;
  logic                 load_use;

  // Load-use hazard: a load in EX writes a non-zero register read by ID.
  always_comb begin
    load_use = i_id_ex_mem_read && (i_id_ex_rt != '0) &&
               ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));
  end

  // Next-state and combinational stage controls.
  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    o_pipe_enable  = 1'b0;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = i_mode ? ST_STEP_WAIT : ST_RUN;
      end
      ST_RUN, ST_STEP_EXEC: begin
        o_pipe_enable = 1'b1;
        // Stall outranks halt and branch; a held halt is retried next cycle.
        if (load_use) begin
          o_id_ex_bubble = 1'b1;
        end else if (i_halt_decoded) begin
          o_if_id_write = 1'b1;
          o_if_id_flush = 1'b1;
          state_d       = ST_DRAIN;
          drain_cnt_d   = DRAIN_LOAD;
        end else begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
          o_if_id_flush = i_branch_taken;
        end
        if ((state_q == ST_STEP_EXEC) && (state_d != ST_DRAIN)) state_d = ST_STEP_WAIT;
      end
      ST_STEP_WAIT: begin
        if (i_step) state_d = ST_STEP_EXEC;
      end
      ST_DRAIN: begin
        o_pipe_enable = 1'b1;
        o_if_id_write = 1'b1;
        o_if_id_flush = 1'b1;
        if (drain_cnt_q == '0) state_d = ST_DONE;
        else drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating count of enabled cycles.
  always_comb begin
    cycle_d = cycle_q;
    if (o_pipe_enable && (cycle_q != '1)) cycle_d = cycle_q + NB_CYCLE'(1);
  end

  // State, drain counter and cycle counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_q     <= cycle_d;
    end
  end

  // Status flags decoded from the state register.
  always_comb begin
    o_running     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    o_done        = (state_q == ST_DONE);
    o_cycle_count = cycle_q;
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: a reference model predicts the
// control outputs each cycle into a scoreboard queue, popped at the negedge.
module tb_pipeline_control;

  logic       clk = 1'b0;
  logic       rst_n, start, mode, step, halt, branch, mem_read;
  logic [4:0] ex_rt, rs, rt;

  logic        pe0, pcw0, ifw0, fl0, bb0, run0, dn0;
  logic [31:0] cnt0;
  logic        pe1, pcw1, ifw1, fl1, bb1, run1, dn1;
  logic [3:0]  cnt1;
  logic [6:0]  ctl0, ctl1;

  assign ctl0 = {pe0, pcw0, ifw0, fl0, bb0, run0, dn0};
  assign ctl1 = {pe1, pcw1, ifw1, fl1, bb1, run1, dn1};

  always #5 clk = ~clk;

  pipeline_control #(.NB_REG_ADDR(5), .NB_CYCLE(32), .DRAIN_CYCLES(4)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_mode(mode), .i_step(step),
    .i_halt_decoded(halt), .i_branch_taken(branch), .i_id_ex_mem_read(mem_read),
    .i_id_ex_rt(ex_rt), .i_if_id_rs(rs), .i_if_id_rt(rt),
    .o_pipe_enable(pe0), .o_pc_write(pcw0), .o_if_id_write(ifw0),
    .o_if_id_flush(fl0), .o_id_ex_bubble(bb0), .o_running(run0), .o_done(dn0),
    .o_cycle_count(cnt0)
  );

  pipeline_control #(.NB_REG_ADDR(5), .NB_CYCLE(4), .DRAIN_CYCLES(4)) u_dut_sat (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_mode(mode), .i_step(step),
    .i_halt_decoded(halt), .i_branch_taken(branch), .i_id_ex_mem_read(mem_read),
    .i_id_ex_rt(ex_rt), .i_if_id_rs(rs), .i_if_id_rt(rt),
    .o_pipe_enable(pe1), .o_pc_write(pcw1), .o_if_id_write(ifw1),
    .o_if_id_flush(fl1), .o_id_ex_bubble(bb1), .o_running(run1), .o_done(dn1),
    .o_cycle_count(cnt1)
  );

  localparam int M_IDLE = 0, M_RUN = 1, M_SWAIT = 2, M_SEXEC = 3, M_DRAIN = 4, M_DONE = 5;

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic [31:0] cnt;
    logic [3:0]  cnt_sat;
  } exp_t;

  exp_t        sb[$];
  int          m_state = M_IDLE;
  int          m_drain = 0;
  logic [31:0] m_count = '0;
  logic [3:0]  m_count_sat = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          en_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_stall();
    return mem_read && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
  endfunction

  // Expected {pe, pc_write, if_id_write, flush, bubble, running, done}.
  function automatic logic [6:0] model_ctl();
    logic pe, pcw, ifw, fl, bb, rn, dn;
    pe = 0; pcw = 0; ifw = 0; fl = 0; bb = 0;
    if (m_state == M_RUN || m_state == M_SEXEC) begin
      pe = 1;
      if (model_stall()) bb = 1;
      else if (halt) begin fl = 1; ifw = 1; end
      else begin pcw = 1; ifw = 1; fl = branch; end
    end else if (m_state == M_DRAIN) begin
      pe = 1; fl = 1; ifw = 1;
    end
    rn = (m_state != M_IDLE) && (m_state != M_DONE);
    dn = (m_state == M_DONE);
    return {pe, pcw, ifw, fl, bb, rn, dn};
  endfunction

  task automatic model_advance();
    logic pe, lu;
    pe = model_ctl()[6];
    lu = model_stall();
    if (!rst_n) begin
      m_state = M_IDLE; m_drain = 0; m_count = '0; m_count_sat = '0;
    end else begin
      if (pe) begin
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        if (m_count_sat != 4'hF) m_count_sat = m_count_sat + 1;
      end
      case (m_state)
        M_IDLE:  if (start) m_state = mode ? M_SWAIT : M_RUN;
        M_RUN:   if (!lu && halt) begin m_state = M_DRAIN; m_drain = 3; end
        M_SWAIT: if (step) m_state = M_SEXEC;
        M_SEXEC: if (!lu && halt) begin m_state = M_DRAIN; m_drain = 3; end
                 else m_state = M_SWAIT;
        M_DRAIN: if (m_drain == 0) m_state = M_DONE; else m_drain = m_drain - 1;
        default: m_state = M_DONE;
      endcase
    end
  endtask

  // One clock cycle: predict, compare at negedge, advance model at posedge.
  task automatic tick(input string tag);
    exp_t e;
    e.tag = tag; e.ctl = model_ctl(); e.cnt = m_count; e.cnt_sat = m_count_sat;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (pe0 === 1'b1) en_seen++;
    check({e.tag, ".ctl"}, 32'(ctl0), 32'(e.ctl));
    check({e.tag, ".ctl_sat"}, 32'(ctl1), 32'(e.ctl));
    check({e.tag, ".cnt"}, cnt0, e.cnt);
    check({e.tag, ".cnt_sat"}, 32'(cnt1), 32'(e.cnt_sat));
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic clr();
    rst_n = 1; start = 0; mode = 0; step = 0; halt = 0; branch = 0; mem_read = 0;
    ex_rt = '0; rs = '0; rt = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with start asserted to show reset dominates.
    start = 1;
    tick("rst"); tick("rst");
    check("rst_pe", 32'(pe0), 32'd0);
    check("rst_cnt", cnt0, 32'd0);
    check("rst_running", 32'(run0), 32'd0);

    // Continuous run, halt on the 10th enabled cycle.
    clr(); start = 1; tick("idle_start"); start = 0;
    en_seen = 0;
    for (int i = 1; i <= 10; i++) begin halt = (i == 10); tick("run"); end
    halt = 0;
    for (int i = 0; i < 4; i++) tick("drain");
    start = 1; step = 1; tick("done_ign"); mode = 1; tick("done_ign"); clr();
    check("run_done", 32'(dn0), 32'd1);
    check("run_count", cnt0, 32'd14);
    check("run_enabled", 32'(en_seen), 32'd14);

    // Hazards in RUN.
    rst_n = 0; tick("rst2"); clr();
    step = 1; tick("idle_step"); step = 0;
    check("idle_step_ign", 32'(run0), 32'd0);
    start = 1; tick("start2"); start = 0;
    mem_read = 1; ex_rt = 5; rs = 5; tick("lu_rs");
    check("lu_pcw", 32'(pcw0), 32'd0);
    check("lu_ifw", 32'(ifw0), 32'd0);
    check("lu_bubble", 32'(bb0), 32'd1);
    ex_rt = 0; rs = 0; tick("lu_r0");
    check("r0_pcw", 32'(pcw0), 32'd1);
    check("r0_bubble", 32'(bb0), 32'd0);
    ex_rt = 7; rs = 3; rt = 7; tick("lu_rt");
    check("lurt_bubble", 32'(bb0), 32'd1);
    clr(); branch = 1; tick("branch");
    check("br_flush", 32'(fl0), 32'd1);
    check("br_pcw", 32'(pcw0), 32'd1);
    mem_read = 1; ex_rt = 5; rs = 5; halt = 1; tick("all3");
    check("all3_running", 32'(run0), 32'd1);
    check("all3_flush", 32'(fl0), 32'd0);
    check("all3_bubble", 32'(bb0), 32'd1);
    mem_read = 0; tick("halt_acc");
    clr();
    for (int i = 0; i < 4; i++) tick("drain2");
    check("hz_done", 32'(dn0), 32'd1);

    // Step mode: three pulses spaced five cycles apart.
    rst_n = 0; tick("rst3"); clr();
    start = 1; mode = 1; tick("step_start"); clr();
    en_seen = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1; tick("step_pulse"); step = 0;
      for (int g = 0; g < 4; g++) begin start = (g == 2); tick("step_gap"); end
      start = 0;
    end
    check("step_enabled", 32'(en_seen), 32'd3);
    check("step_count", cnt0, 32'd3);
    check("step_running", 32'(run0), 32'd1);
    step = 1; tick("step_h"); step = 0; halt = 1; tick("step_halt"); halt = 0;
    tick("sdrain"); tick("sdrain");
    // Reset mid-drain, then a normal restart.
    rst_n = 0; start = 1; tick("rst_drain"); clr();
    check("rd_running", 32'(run0), 32'd0);
    check("rd_cnt", cnt0, 32'd0);
    check("rd_pe", 32'(pe0), 32'd0);
    start = 1; tick("restart"); start = 0;
    for (int i = 0; i < 3; i++) tick("rerun");
    check("rerun_running", 32'(run0), 32'd1);
    check("rerun_cnt", cnt0, 32'd3);

    // Twenty enabled cycles: narrow counter saturates.
    rst_n = 0; tick("rst4"); clr();
    start = 1; tick("start4"); start = 0;
    for (int i = 1; i <= 16; i++) begin halt = (i == 16); tick("run20"); end
    halt = 0;
    for (int i = 0; i < 4; i++) tick("drain20");
    check("sat_wide", cnt0, 32'd20);
    check("sat_narrow", 32'(cnt1), 32'd15);
    check("sat_done", 32'(dn1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter NB_REG_ADDR, default 5: register-address width.
REQ-002 SHALL have parameter NB_CYCLE, default 32: cycle-counter width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4: enabled cycles needed to retire a HALT (ID->WB).
REQ-004 SHALL have port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous, active-low reset.
REQ-006 SHALL have port i_start, input, 1, pulse that launches execution from IDLE.
REQ-007 SHALL have port i_mode, input, 1, 0 = continuous, 1 = step; sampled only with i_start.
REQ-008 SHALL have port i_step, input, 1, pulse requesting one pipeline cycle in step mode.
REQ-009 SHALL have port i_halt_decoded, input, 1, HALT opcode present in the ID stage.
REQ-010 SHALL have port i_branch_taken, input, 1, branch/jump resolved taken in ID.
REQ-011 SHALL have port i_id_ex_mem_read, input, 1, instruction in EX is a load.
REQ-012 SHALL have port i_id_ex_rt, input, NB_REG_ADDR, load destination register.
REQ-013 SHALL have ports i_if_id_rs and i_if_id_rt, input, NB_REG_ADDR, source registers of the instruction in ID.
REQ-014 SHALL have port o_pipe_enable, output, 1, global enable for all stage registers.
REQ-015 SHALL have port o_pc_write, output, 1, PC update enable.
REQ-016 SHALL have port o_if_id_write, output, 1, IF/ID register update enable.
REQ-017 SHALL have port o_if_id_flush, output, 1, load NOP into IF/ID.
REQ-018 SHALL have port o_id_ex_bubble, output, 1, load NOP into ID/EX.
REQ-019 SHALL have port o_running, output, 1, high in every state except IDLE and DONE.
REQ-020 SHALL have port o_done, output, 1, high only in DONE.
REQ-021 SHALL have port o_cycle_count, output, NB_CYCLE, number of cycles with o_pipe_enable=1.

Function
REQ-022 SHALL implement FSM states IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN and DONE.
REQ-023 In IDLE: i_start with i_mode=0 -> RUN; i_start with i_mode=1 -> STEP_WAIT; i_step ignored.
REQ-024 In RUN: o_pipe_enable=1; an accepted halt -> DRAIN.
REQ-025 In STEP_WAIT: o_pipe_enable=0; i_step -> STEP_EXEC; i_start ignored.
REQ-026 In STEP_EXEC: exactly one cycle with o_pipe_enable=1; next state is STEP_WAIT, or DRAIN if a halt is accepted.
REQ-027 In DRAIN: o_pipe_enable=1 regardless of mode, o_pc_write=0, o_if_id_flush=1; a down-counter loaded with DRAIN_CYCLES-1 on entry moves to DONE when it reads 0, so DRAIN lasts DRAIN_CYCLES cycles.
REQ-028 In DONE: o_pipe_enable=0 and o_done=1; all inputs ignored until reset.
REQ-029 Load-use stall SHALL be: i_id_ex_mem_read AND i_id_ex_rt!=0 AND (i_id_ex_rt==i_if_id_rs OR i_id_ex_rt==i_if_id_rt).
REQ-030 During a stall in an enabled cycle: o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1, o_if_id_flush=0.
REQ-031 Taken branch without a stall in an enabled cycle: o_if_id_flush=1, o_pc_write=1.
REQ-032 Stall SHALL take priority over branch and halt; a halt is accepted only in an enabled, non-stalled RUN/STEP_EXEC cycle.
REQ-033 In the halt-accept cycle: o_pc_write=0, o_if_id_flush=1.
REQ-034 Enabled cycle with no event: o_pc_write=1, o_if_id_write=1, flush=0, bubble=0.
REQ-035 When o_pipe_enable=0, o_pc_write, o_if_id_write, o_if_id_flush and o_id_ex_bubble SHALL all be 0.
REQ-036 o_pipe_enable, o_pc_write, o_if_id_write, o_if_id_flush and o_id_ex_bubble SHALL be combinational from state and inputs, with 0-cycle latency.
REQ-037 o_cycle_count SHALL increment once per enabled cycle and saturate at all-ones.

Reset
REQ-038 i_rst=0 at a rising edge SHALL set state=IDLE, drain counter=0 and o_cycle_count=0, giving o_running=0, o_done=0, o_pipe_enable=0, with every control output 0.
REQ-039 Reset asserted in any state, including mid-DRAIN or mid-step, SHALL take effect at that edge and override all other inputs.

Verification
REQ-040 Bench SHALL drive continuous run (i_mode=0, i_start, no hazards, halt at cycle 10) -> o_pipe_enable high for 10+4 cycles, then o_done=1 and o_cycle_count=14.
REQ-041 Bench SHALL apply load-use (mem_read=1, id_ex_rt=5, if_id_rs=5) -> same cycle o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1; with id_ex_rt=0 -> no stall.
REQ-042 Bench SHALL apply stall, branch and halt together in RUN -> stall outputs only, state stays RUN, and the halt is accepted the next non-stalled cycle.
REQ-043 Bench SHALL exercise step mode (i_mode=1, i_start, three i_step pulses spaced 5 cycles apart) -> exactly 3 enabled cycles and o_cycle_count=3.
REQ-044 Bench SHALL pulse i_rst=0 during DRAIN -> next edge IDLE and count 0; a following i_start restarts normally.
REQ-045 Bench SHALL run with NB_CYCLE=4 and 20 enabled cycles -> o_cycle_count holds at 15.
